sargantana_icache_refill: RTL and testbench
===========================================

Name: sargantana_icache_refill

Overview:
- Refill assembler directly upstream of the per-way set RAMs of the instruction cache.
- On a miss it captures set index and victim way, then collects BEAT_WIDTH response beats from the L2/NoC over a valid/ready handshake into one LINE_WIDTH line.
- It then issues a single-cycle write (req/we/addr/data) to the selected way's set RAM.
- Also handles flush aborts and bus errors, so a partial or corrupt line never reaches the array.

Parameters:
- LINE_WIDTH, 256, cache line width in bits; equals the set RAM data width.
- BEAT_WIDTH, 64, response beat width; LINE_WIDTH must be an integer multiple of it.
- ADDR_WIDTH, 6, set index width; equals the set RAM address width.
- N_WAYS, 4, number of ways; one set RAM per way.
- Derived: N_BEATS = LINE_WIDTH/BEAT_WIDTH (4); WAY_W = max(1, clog2(N_WAYS)).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- miss_i  in  1  start-refill request, sampled only in IDLE.
- miss_idx_i  in  ADDR_WIDTH  set index of the missing line.
- miss_way_i  in  WAY_W  victim way to be written.
- flush_i  in  1  abort any refill in progress.
- beat_valid_i  in  1  response beat valid.
- beat_ready_o  out  1  beat accept.
- beat_data_i  in  BEAT_WIDTH  response beat payload, lowest beat first.
- beat_err_i  in  1  beat carries a bus error.
- ram_req_o  out  N_WAYS  one-hot per-way set RAM request.
- ram_we_o  out  1  set RAM write enable.
- ram_addr_o  out  ADDR_WIDTH  set RAM address.
- ram_data_o  out  LINE_WIDTH  assembled line.
- busy_o  out  1  refill in progress (state != IDLE).
- done_o  out  1  one-cycle pulse: line written.
- err_o  out  1  one-cycle pulse: refill ended with a bus error, no write.

Behaviour:
- Reset (async assert, sync release): state=IDLE; beat counter, error flag, idx/way registers and line buffer cleared; all outputs 0.
- States: IDLE, FILL, WRITE, DRAIN.
- IDLE:
  - beat_ready_o=0.
  - miss_i=1 and flush_i=0: latch idx/way, clear counter and error flag, go to FILL.
  - flush_i=1 takes priority over miss_i in the same cycle: the miss is dropped and the block stays in IDLE.
- FILL:
  - beat_ready_o=1.
  - On each handshake (valid&ready), beat_data_i is written to line bits [cnt*BEAT_WIDTH +: BEAT_WIDTH], cnt increments, and the error flag ORs in beat_err_i.
  - On handshake of beat N_BEATS-1: error flag (including this beat) set -> pulse err_o next cycle and go to IDLE, no write; otherwise go to WRITE.
  - flush_i=1 in FILL: go to DRAIN; a beat handshaking in that same cycle is counted but the line is discarded.
  - If that beat was the last one, go to IDLE instead, with no write and no pulse.
- DRAIN:
  - beat_ready_o=1; accept and discard beats until N_BEATS have been consumed in total, then go to IDLE.
  - No write, no done_o, no err_o.
  - miss_i is ignored in DRAIN.
- WRITE (exactly one cycle):
  - ram_req_o = one-hot(way), ram_we_o=1, ram_addr_o=idx, ram_data_o=line, done_o=1; next state IDLE.
  - flush_i=1 in WRITE suppresses the write (req/we/done all 0) and the block goes to IDLE.
- ram_req_o, ram_we_o and done_o are 0 in every state except WRITE.
- ram_addr_o and ram_data_o are don't-care when ram_req_o=0; they are driven from registers.
- Latency: miss accept to write = N_BEATS handshake cycles + 1 cycle; minimum 5 cycles at defaults (miss at cycle 0, beats at cycles 1-4, write at cycle 5).
- miss_i outside IDLE is ignored; the requester holds it until busy_o=0.
- beat_valid_i with beat_ready_o=0 is not consumed, and the beat's data is not sampled.
- Counter width is clog2(N_BEATS)+1 with no wrap inside a refill; the counter is cleared on entry to FILL.
- Reset asserted mid-refill: immediate return to IDLE, no write; any partial line is lost.

Test Plan:
- Basic refill: miss idx=0x2A way=2; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> at cycle 5 ram_req_o=4'b0100, we=1, addr=0x2A, data={0x44..,0x33..,0x22..,0x11..}; done_o=1 for exactly 1 cycle; busy_o low next cycle.
- Backpressure gaps: same line with beat_valid_i gapped (cycles 1, 3, 4, 7) -> a single write with the identical line occurs the cycle after the 4th handshake; beats are never double-counted.
- Error beat: beat_err_i=1 on beat 1 -> all 4 beats accepted, err_o pulses once, ram_req_o stays 0.
- Flush mid-fill: flush_i after 2 beats -> DRAIN accepts 2 more beats, then IDLE; no write, no done_o/err_o. A new miss in the next cycle completes normally.
- Flush in WRITE and flush+miss in IDLE: ram_req_o stays 0 and the block returns to IDLE; the simultaneous flush+miss leaves busy_o=0.
- Async reset after 3 beats: outputs go 0 immediately without a clock edge. A following refill to way 0, idx 0x3F writes only the new data.

Source files
------------

// File: rtl/sargantana_icache_refill_if.sv
// Refill-side bus bundle: L2/NoC response beats in, per-way set RAM write out.
// Latency: none (wires only).
// Backpressure: beat_ready_o qualifies beat_valid_i; RAM side has no backpressure.
interface sargantana_icache_refill_if #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int N_WAYS     = 4
);
    logic                  beat_valid_i;
    logic                  beat_ready_o;
    logic [BEAT_WIDTH-1:0] beat_data_i;
    logic                  beat_err_i;
    logic [N_WAYS-1:0]     ram_req_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [LINE_WIDTH-1:0] ram_data_o;

    modport slave (
        input  beat_valid_i, beat_data_i, beat_err_i,
        output beat_ready_o, ram_req_o, ram_we_o, ram_addr_o, ram_data_o
    );

    modport master (
        output beat_valid_i, beat_data_i, beat_err_i,
        input  beat_ready_o, ram_req_o, ram_we_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/sargantana_icache_refill.sv
// I-cache refill assembler: gathers N_BEATS response beats into one line, writes it to the victim way.
// Latency: miss accept to RAM write = N_BEATS handshakes + 1 cycle (5 cycles minimum at defaults).
// Backpressure: beats accepted only in FILL/DRAIN; the RAM write is a single unstalled cycle.
module sargantana_icache_refill #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int N_WAYS     = 4,
    localparam int WAY_W     = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  miss_i,
    input  logic [ADDR_WIDTH-1:0] miss_idx_i,
    input  logic [WAY_W-1:0]      miss_way_i,
    input  logic                  flush_i,
    sargantana_icache_refill_if.slave bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int N_BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W   = $clog2(N_BEATS) + 1;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_flag_q, err_flag_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [WAY_W-1:0]      way_q, way_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  hs;
    logic                  last;

    assign hs   = bus.beat_valid_i & bus.beat_ready_o;
    assign last = hs && (cnt_q == CNT_W'(N_BEATS - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            way_q      <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            way_q      <= way_d;
            line_q     <= line_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        err_d      = 1'b0;
        idx_d      = idx_q;
        way_d      = way_q;
        line_d     = line_q;
        case (state_q)
            IDLE: begin
                if (miss_i && !flush_i) begin
                    state_d    = FILL;
                    idx_d      = miss_idx_i;
                    way_d      = miss_way_i;
                    cnt_d      = '0;
                    err_flag_d = 1'b0;
                end
            end
            FILL: begin
                if (hs) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    err_flag_d = err_flag_q | bus.beat_err_i;
                    for (int b = 0; b < N_BEATS; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = bus.beat_data_i;
                        end
                    end
                end
                // A flush that lands on the final beat has nothing left to drain.
                if (flush_i) begin
                    state_d = last ? IDLE : DRAIN;
                end else if (last) begin
                    if (err_flag_q || bus.beat_err_i) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            DRAIN: begin
                if (hs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (last) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.beat_ready_o = (state_q == FILL) || (state_q == DRAIN);
        bus.ram_req_o    = '0;
        bus.ram_we_o     = 1'b0;
        done_o           = 1'b0;
        if (state_q == WRITE && !flush_i) begin
            for (int w = 0; w < N_WAYS; w++) begin
                bus.ram_req_o[w] = (way_q == WAY_W'(w));
            end
            bus.ram_we_o = 1'b1;
            done_o       = 1'b1;
        end
    end

    assign bus.ram_addr_o = idx_q;
    assign bus.ram_data_o = line_q;
    assign busy_o         = (state_q != IDLE);
    assign err_o          = err_q;
endmodule

// File: tb/tb_sargantana_icache_refill.sv
// Directed bench for the i-cache refill assembler: per-cycle vector table plus async-reset sequence.
module tb_sargantana_icache_refill;
    localparam int LW = 256;
    localparam int BW = 64;
    localparam int AW = 6;
    localparam int NW = 4;
    localparam int WW = 2;

    localparam logic [BW-1:0] B1 = {16{4'h1}};
    localparam logic [BW-1:0] B2 = {16{4'h2}};
    localparam logic [BW-1:0] B3 = {16{4'h3}};
    localparam logic [BW-1:0] B4 = {16{4'h4}};
    localparam logic [BW-1:0] BX = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [BW-1:0] C1 = 64'hC1C1_0000_0000_00C1;
    localparam logic [BW-1:0] C2 = 64'hC2C2_0000_0000_00C2;
    localparam logic [BW-1:0] C3 = 64'hC3C3_0000_0000_00C3;
    localparam logic [BW-1:0] C4 = 64'hC4C4_0000_0000_00C4;
    localparam logic [LW-1:0] L1 = {B4, B3, B2, B1};
    localparam logic [LW-1:0] L2 = {B1, B2, B3, B4};
    localparam logic [LW-1:0] LC = {C4, C3, C2, C1};

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          miss = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] midx = '0;
    logic [WW-1:0] mway = '0;
    logic          busy, done, err;

    sargantana_icache_refill_if #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW), .N_WAYS(NW)) bus ();

    sargantana_icache_refill #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW), .N_WAYS(NW)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .miss_i     (miss),
        .miss_idx_i (midx),
        .miss_way_i (mway),
        .flush_i    (flush),
        .bus        (bus),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          miss;
        logic [AW-1:0] idx;
        logic [WW-1:0] way;
        logic          flush;
        logic          vld;
        logic [BW-1:0] dat;
        logic          berr;
        logic          e_rdy;
        logic [NW-1:0] e_req;
        logic          e_busy;
        logic          e_err;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_line;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic m, input logic [AW-1:0] i, input logic [WW-1:0] w,
                       input logic f, input logic v, input logic [BW-1:0] d, input logic be,
                       input logic er, input logic [NW-1:0] rq, input logic eb, input logic ee,
                       input logic [AW-1:0] ea, input logic [LW-1:0] el);
        vec_t t;
        t.miss = m; t.idx = i; t.way = w; t.flush = f; t.vld = v; t.dat = d; t.berr = be;
        t.e_rdy = er; t.e_req = rq; t.e_busy = eb; t.e_err = ee; t.e_addr = ea; t.e_line = el;
        tbl.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        miss = 1'b0; flush = 1'b0;
        bus.beat_valid_i = 1'b0; bus.beat_data_i = '0; bus.beat_err_i = 1'b0;
    endtask

    task automatic beat(input logic [BW-1:0] d);
        bus.beat_valid_i = 1'b1; bus.beat_data_i = d;
        step();
    endtask

    initial begin
        idle_inputs();

        // basic refill; miss held with another idx while busy must be ignored
        add(1, 6'h2A, 2, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        add(1, 6'h01, 1, 0, 1, B1, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(1, 6'h01, 1, 0, 1, B2, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(1, 6'h01, 1, 0, 1, B3, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(1, 6'h01, 1, 0, 1, B4, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0100, 1, 0, 6'h2A, L1);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        // gapped beats at cycles 1,3,4,7; invalid cycles carry junk data
        add(1, 6'h2A, 2, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B1, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, BX, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B2, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B3, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, BX, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, BX, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B4, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, BX, 0,  0, 4'b0100, 1, 0, 6'h2A, L1);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        // bus error on beat 1: all beats taken, single err pulse, no write
        add(1, 6'h05, 1, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B1, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B2, 1,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B3, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B4, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0000, 0, 1, 0, '0);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        // flush after two beats, drain two more, then a clean refill to way 0
        add(1, 6'h10, 3, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B1, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B2, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 1, 0, '0, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(1, 6'h22, 2, 0, 1, B3, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(1, 6'h22, 2, 0, 1, B4, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(1, 6'h11, 0, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B4, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B3, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B2, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B1, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0001, 1, 0, 6'h11, L2);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        // flush during the write cycle suppresses it
        add(1, 6'h07, 1, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B1, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B2, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B3, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B4, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 1, 0, '0, 0,  0, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        // flush coinciding with the last beat: straight to idle, silent
        add(1, 6'h08, 3, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B1, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B2, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, B3, 0,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 1, 1, B4, 1,  1, 4'b0000, 1, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        // flush and miss together in idle: miss dropped
        add(1, 6'h09, 1, 1, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);
        add(0, 6'h00, 0, 0, 1, BX, 0,  0, 4'b0000, 0, 0, 0, '0);
        add(0, 6'h00, 0, 0, 0, '0, 0,  0, 4'b0000, 0, 0, 0, '0);

        // reset state
        #3;
        chk("rst busy", LW'(busy), LW'(0));
        chk("rst rdy", LW'(bus.beat_ready_o), LW'(0));
        chk("rst req", LW'(bus.ram_req_o), LW'(0));
        chk("rst we", LW'(bus.ram_we_o), LW'(0));
        chk("rst done", LW'(done), LW'(0));
        chk("rst err", LW'(err), LW'(0));
        chk("rst addr", LW'(bus.ram_addr_o), LW'(0));
        chk("rst data", bus.ram_data_o, '0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        for (int r = 0; r < tbl.size(); r++) begin
            miss = tbl[r].miss; midx = tbl[r].idx; mway = tbl[r].way; flush = tbl[r].flush;
            bus.beat_valid_i = tbl[r].vld; bus.beat_data_i = tbl[r].dat; bus.beat_err_i = tbl[r].berr;
            #1;
            chk($sformatf("row%0d rdy", r), LW'(bus.beat_ready_o), LW'(tbl[r].e_rdy));
            chk($sformatf("row%0d req", r), LW'(bus.ram_req_o), LW'(tbl[r].e_req));
            chk($sformatf("row%0d we", r), LW'(bus.ram_we_o), LW'(tbl[r].e_req != 0));
            chk($sformatf("row%0d done", r), LW'(done), LW'(tbl[r].e_req != 0));
            chk($sformatf("row%0d busy", r), LW'(busy), LW'(tbl[r].e_busy));
            chk($sformatf("row%0d err", r), LW'(err), LW'(tbl[r].e_err));
            if (tbl[r].e_req != 0) begin
                chk($sformatf("row%0d addr", r), LW'(bus.ram_addr_o), LW'(tbl[r].e_addr));
                chk($sformatf("row%0d data", r), bus.ram_data_o, tbl[r].e_line);
            end
            @(posedge clk);
            #1;
        end

        // async reset after three beats, then a refill to way 0 idx 0x3F
        idle_inputs();
        miss = 1'b1; midx = 6'h15; mway = 2'd3;
        step();
        miss = 1'b0;
        beat(B1); beat(B2); beat(B3);
        idle_inputs();
        chk("pre-rst busy", LW'(busy), LW'(1));
        #1 rstn = 1'b0;
        #1;
        chk("arst busy", LW'(busy), LW'(0));
        chk("arst rdy", LW'(bus.beat_ready_o), LW'(0));
        chk("arst req", LW'(bus.ram_req_o), LW'(0));
        chk("arst done", LW'(done), LW'(0));
        chk("arst err", LW'(err), LW'(0));
        chk("arst data", bus.ram_data_o, '0);
        #1 rstn = 1'b1;
        step();
        miss = 1'b1; midx = 6'h3F; mway = 2'd0;
        step();
        miss = 1'b0;
        beat(C1); beat(C2); beat(C3); beat(C4);
        idle_inputs();
        #1;
        chk("post req", LW'(bus.ram_req_o), LW'(4'b0001));
        chk("post we", LW'(bus.ram_we_o), LW'(1));
        chk("post done", LW'(done), LW'(1));
        chk("post addr", LW'(bus.ram_addr_o), LW'(6'h3F));
        chk("post data", bus.ram_data_o, LC);
        step();
        chk("post idle busy", LW'(busy), LW'(0));
        chk("post idle done", LW'(done), LW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
